// File: rtl/qam_frame_ctrl.sv
// qam_frame_ctrl
//    Frame controller behind a 16-QAM demodulation chain. After a start
//    request it enables the chain and hunts the symbol stream for the sync
//    word. It then packs the following payload nibbles into bytes and queues
//    them in a 4-entry output FIFO.
//
// Parameters
//    SYNC_WORD      16-bit sync pattern. The most significant nibble arrives first.
//    PAYLOAD_BYTES  payload bytes per frame (1..255)
//    TIMEOUT        idle cycles allowed between payload symbols (1..65535)
//
// Ports
//    axi_clk     clock, rising edge
//    axi_rst     synchronous active-high reset
//    start       one-cycle request to leave IDLE and hunt for sync
//    abort       one-cycle request to return to IDLE and flush the FIFO
//    chain_en    enable for the demod chain, high outside IDLE
//    sym_valid   symbol strobe from the demod chain
//    sym         demodulated 4-bit symbol
//    m_valid     output byte valid (FIFO not empty)
//    m_data      output byte (FIFO head)
//    m_last      head byte is the last byte of its frame
//    m_ready     downstream accept
//    frame_done  pulse when the last byte of a frame is written (or dropped)
//    sync_lost   pulse on payload timeout
//    overflow    sticky: a byte was dropped because the FIFO was full
module qam_frame_ctrl #(
   parameter logic [15:0] SYNC_WORD     = 16'hEB90,
   parameter int unsigned PAYLOAD_BYTES = 64,
   parameter int unsigned TIMEOUT       = 1023
) (
   input  logic       axi_clk,
   input  logic       axi_rst,
   input  logic       start,
   input  logic       abort,
   output logic       chain_en,
   input  logic       sym_valid,
   input  logic [3:0] sym,
   output logic       m_valid,
   output logic [7:0] m_data,
   output logic       m_last,
   input  logic       m_ready,
   output logic       frame_done,
   output logic       sync_lost,
   output logic       overflow
);

   typedef enum logic [1:0] {IDLE, HUNT, PAYLOAD} state_t;

   localparam logic [7:0]  LAST_IDX = 8'(PAYLOAD_BYTES - 1);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   logic [11:0] sync_sr;      // last three hunt nibbles; the current symbol completes the word
   logic [2:0]  sym_cnt;      // hunt symbols since entering HUNT, saturates at 4
   logic        nib_phase;    // 1 = high nibble held, waiting for the low nibble
   logic [3:0]  hi_nib;
   logic [7:0]  byte_cnt;
   logic [15:0] tmo_cnt;
   logic        wr_pend;      // byte assembled last cycle, written to the FIFO this cycle
   logic [8:0]  wr_entry;     // {last, data}

   // Shift-register FIFO. Entry 0 is always the head, so the outputs come straight from flops.
   logic [8:0]  fifo_mem [4];
   logic [3:0]  fifo_vld;     // thermometer code: occupied entries are packed toward entry 0
   logic [8:0]  mem_nxt [4];
   logic [3:0]  vld_nxt;
   logic        placed;
   logic        pop;
   logic        drop;
   logic [15:0] sr_shift;

   assign sr_shift = {sync_sr, sym};
   assign pop      = fifo_vld[0] & m_ready;
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign drop     = wr_pend & fifo_vld[3] & ~pop;

   assign m_valid  = fifo_vld[0];
   assign m_data   = fifo_mem[0][7:0];
   assign m_last   = fifo_mem[0][8];

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no latch can be inferred.
      mem_nxt = fifo_mem;
      vld_nxt = fifo_vld;
      placed  = 1'b0;
      if (pop) begin
         for (int i = 0; i < 3; i++) begin
            mem_nxt[i] = fifo_mem[i+1];
            vld_nxt[i] = fifo_vld[i+1];
         end
         vld_nxt[3] = 1'b0;
      end
      if (wr_pend && !drop) begin
         for (int i = 0; i < 4; i++) begin
            if (!placed && !vld_nxt[i]) begin
               mem_nxt[i] = wr_entry;
               vld_nxt[i] = 1'b1;
               placed     = 1'b1;
            end
         end
      end
   end

   // NOTE: all state updates use non-blocking assignments, so every branch reads pre-edge values.
   always_ff @(posedge axi_clk) begin
      if (axi_rst) begin
         state      <= IDLE;
         chain_en   <= 1'b0;
         sync_sr    <= '0;
         sym_cnt    <= '0;
         nib_phase  <= 1'b0;
         hi_nib     <= '0;
         byte_cnt   <= '0;
         tmo_cnt    <= '0;
         wr_pend    <= 1'b0;
         wr_entry   <= '0;
         // NOTE: the FIFO storage is reset because its head entry drives m_data/m_last directly.
         fifo_mem   <= '{default: '0};
         fifo_vld   <= '0;
         frame_done <= 1'b0;
         sync_lost  <= 1'b0;
         overflow   <= 1'b0;
      end else if (abort) begin
         // Abort wins over everything else. The overflow flag survives it.
         state      <= IDLE;
         chain_en   <= 1'b0;
         sync_sr    <= '0;
         sym_cnt    <= '0;
         nib_phase  <= 1'b0;
         byte_cnt   <= '0;
         tmo_cnt    <= '0;
         wr_pend    <= 1'b0;
         fifo_vld   <= '0;
         frame_done <= 1'b0;
         sync_lost  <= 1'b0;
      end else begin
         fifo_mem   <= mem_nxt;
         fifo_vld   <= vld_nxt;
         overflow   <= overflow | drop;
         frame_done <= wr_pend & wr_entry[8];
         sync_lost  <= 1'b0;
         wr_pend    <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  state     <= HUNT;
                  chain_en  <= 1'b1;
                  sync_sr   <= '0;
                  sym_cnt   <= '0;
                  nib_phase <= 1'b0;
                  byte_cnt  <= '0;
                  tmo_cnt   <= '0;
               end
            end

            HUNT: begin
               if (sym_valid) begin
                  sync_sr <= sr_shift[11:0];
                  if (sym_cnt != 3'd4) sym_cnt <= sym_cnt + 3'd1;
                  // Only a word built entirely from this hunt's own symbols may match.
                  if (sym_cnt >= 3'd3 && sr_shift == SYNC_WORD) begin
                     state     <= PAYLOAD;
                     nib_phase <= 1'b0;
                     byte_cnt  <= '0;
                     tmo_cnt   <= '0;
                  end
               end
            end

            PAYLOAD: begin
               if (sym_valid) begin
                  tmo_cnt <= '0;
                  if (!nib_phase) begin
                     hi_nib    <= sym;
                     nib_phase <= 1'b1;
                  end else begin
                     nib_phase <= 1'b0;
                     wr_pend   <= 1'b1;
                     wr_entry  <= {byte_cnt == LAST_IDX, hi_nib, sym};
                     if (byte_cnt == LAST_IDX) begin
                        // Frame complete: hunt again right away for a back-to-back frame.
                        byte_cnt <= '0;
                        state    <= HUNT;
                        sync_sr  <= '0;
                        sym_cnt  <= '0;
                     end else begin
                        byte_cnt <= byte_cnt + 8'd1;
                     end
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  // Timeout: drop the partial nibble. Bytes already queued stay in the FIFO.
                  sync_lost <= 1'b1;
                  state     <= HUNT;
                  sync_sr   <= '0;
                  sym_cnt   <= '0;
                  nib_phase <= 1'b0;
                  byte_cnt  <= '0;
                  tmo_cnt   <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end

            default: begin
               state    <= IDLE;
               chain_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/qam_frame_ctrl.md
QAM_FRAME_CTRL -- requirements
Module: qam_frame_ctrl

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 16'hEB90: frame sync pattern, matched MSB-nibble first.
REQ-002 SHALL have parameter PAYLOAD_BYTES, default 64: payload bytes per frame, legal range 1..255.
REQ-003 SHALL have parameter TIMEOUT, default 1023: maximum idle cycles between symbols in PAYLOAD, legal range 1..65535.
REQ-004 SHALL have port axi_clk  input  1: sole clock, all logic on rising edge.
REQ-005 SHALL have port axi_rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1: one-cycle request to begin frame reception.
REQ-007 SHALL have port abort  input  1: one-cycle request to stop and return to IDLE.
REQ-008 SHALL have port chain_en  output  1: enable to the demod chain (cordic, demult, defilter, demod).
REQ-009 SHALL have port sym_valid  input  1: demodulated symbol strobe from the demod chain.
REQ-010 SHALL have port sym  input  4: demodulated 16-QAM symbol.
REQ-011 SHALL have port m_valid  output  1: output byte valid.
REQ-012 SHALL have port m_data  output  8: output byte.
REQ-013 SHALL have port m_last  output  1: marks the final payload byte of a frame.
REQ-014 SHALL have port m_ready  input  1: downstream accept; transfer when m_valid and m_ready.
REQ-015 SHALL have port frame_done  output  1: one-cycle pulse when the last payload byte enters the FIFO.
REQ-016 SHALL have port sync_lost  output  1: one-cycle pulse on payload timeout.
REQ-017 SHALL have port overflow  output  1: sticky flag, byte dropped because the FIFO was full.

Function
REQ-018 SHALL implement states IDLE, HUNT, PAYLOAD; chain_en SHALL be 1 in HUNT and PAYLOAD and 0 in IDLE.
REQ-019 IDLE: start -> HUNT next cycle, with the sync shift register, nibble phase, byte count and timeout counter cleared; start in HUNT or PAYLOAD SHALL be ignored.
REQ-020 HUNT: each sym_valid shifts sym into a 16-bit register as the new LSB nibble; when the post-shift value equals SYNC_WORD, the state SHALL become PAYLOAD on the next cycle.
REQ-021 Sync detection SHALL need 4 symbols received since entering HUNT; stale register contents SHALL never match.
REQ-022 PAYLOAD: nibbles pair into bytes, first nibble = m_data[7:4], second = m_data[3:0]; on the second nibble the byte SHALL be written to the FIFO the following cycle.
REQ-023 The byte with index PAYLOAD_BYTES-1 SHALL be written with m_last=1 and frame_done pulsed in the same cycle; state -> HUNT (sync register cleared) for back-to-back frames.
REQ-024 Timeout counter SHALL clear on each sym_valid in PAYLOAD and increment otherwise; when it reaches TIMEOUT, sync_lost SHALL pulse for one cycle, state -> HUNT, the partial nibble SHALL be discarded, and bytes already written SHALL stay in the FIFO.
REQ-025 abort in any state SHALL go to IDLE next cycle, flush the FIFO (m_valid=0), clear the counters; overflow SHALL be kept; abort SHALL take priority over start, sync match and timeout in the same cycle.
REQ-026 The output SHALL be a 4-entry byte FIFO storing {last, data}; m_valid = not empty; m_data/m_last = head entry; the head pops on m_valid&&m_ready.
REQ-027 Simultaneous push and pop when full SHALL succeed without loss; a push when full and not popping SHALL drop the byte and set overflow.
REQ-028 A dropped last byte SHALL still pulse frame_done and return to HUNT.
REQ-029 sym_valid in IDLE SHALL be ignored.
REQ-030 Outputs SHALL be registered; latency from the second nibble's sym_valid to m_valid on an empty FIFO SHALL be 2 cycles.

Reset
REQ-031 While axi_rst=1 at a clock edge: state=IDLE, chain_en=0, m_valid=0, m_data=0, m_last=0, frame_done=0, sync_lost=0, overflow=0, FIFO empty, all counters and registers 0.
REQ-032 Reset mid-frame SHALL discard all partial and buffered data; first legal start is the cycle after axi_rst deasserts.

Verification
REQ-033 Basic frame: start, symbols E,B,9,0 then 1,2,3,4 with PAYLOAD_BYTES=2, m_ready=1 -> bytes 0x12, 0x34 with m_last=0,1; frame_done pulse on the 0x34 write; state HUNT.
REQ-034 False sync: symbols A,E,B,9,0,5,6 -> sync on the 0 symbol only, first byte 0x56; also E,B,9 directly after start preceded by stale data -> no match.
REQ-035 Timeout: TIMEOUT=8, sync then symbol 7 then 8 idle cycles -> sync_lost pulse, no byte written, next sync + 3,C -> byte 0x3C.
REQ-036 Backpressure: m_ready=0, PAYLOAD_BYTES=6 -> 4 bytes held, 5th and 6th dropped, overflow=1, frame_done still pulses; then m_ready=1 -> exactly 4 bytes drained in order.
REQ-037 Abort priority: abort and start in the same cycle during PAYLOAD with 2 bytes buffered -> IDLE, chain_en=0, m_valid=0 next cycle, overflow unchanged.
REQ-038 Reset mid-frame: axi_rst=1 for 1 cycle after 3 payload bytes -> all outputs at reset values; then start + full frame -> correct bytes.
